// File: rtl/gp_pkg.sv
//============================================================================
// Module : gp_pkg
// Brief  : Shared word width, config register map and FSM encoding for the
//          graphics-pipeline sequencer.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package gp_pkg;

  localparam int c_w        = 16;
  localparam int c_num_regs = 16;

  localparam int c_addr_cam_ver_x  = 0;
  localparam int c_addr_cam_ver_y  = 1;
  localparam int c_addr_cam_ver_z  = 2;
  localparam int c_addr_cam_dc     = 3;
  localparam int c_addr_cos_roll   = 4;
  localparam int c_addr_cos_pitch  = 5;
  localparam int c_addr_cos_yaw    = 6;
  localparam int c_addr_sen_roll   = 7;
  localparam int c_addr_sen_pitch  = 8;
  localparam int c_addr_sen_yaw    = 9;
  localparam int c_addr_scale_x    = 10;
  localparam int c_addr_scale_y    = 11;
  localparam int c_addr_scale_z    = 12;
  localparam int c_addr_transl_x   = 13;
  localparam int c_addr_transl_y   = 14;
  localparam int c_addr_transl_z   = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gp_sequencer_if.sv
//============================================================================
// Module : gp_sequencer_if
// Brief  : Config, vertex, pipeline-parameter and pixel signals of the
//          sequencer; slave = sequencer side, master = host/pipeline side.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface gp_sequencer_if #(
  parameter int W = gp_pkg::c_w
) ();

  logic         i_CfgWe;
  logic [4:0]   i_CfgAddr;
  logic [W-1:0] i_CfgData;
  logic         o_CfgErr;

  logic         i_Start;
  logic [15:0]  i_VtxCount;

  logic         i_VtxValid;
  logic         o_VtxReady;
  logic [W-1:0] i_VertexX, i_VertexY, i_VertexZ;

  logic [W-1:0] o_CamVerX, o_CamVerY, o_CamVerZ, o_CamDc;
  logic [W-1:0] o_CosRoll, o_CosPitch, o_CosYaw;
  logic [W-1:0] o_SenRoll, o_SenPitch, o_SenYaw;
  logic [W-1:0] o_ScaleX, o_ScaleY, o_ScaleZ;
  logic [W-1:0] o_TranslX, o_TranslY, o_TranslZ;
  logic [W-1:0] o_VertexX, o_VertexY, o_VertexZ;

  logic [W-1:0] i_GpPixX, i_GpPixY;

  logic         o_PixValid;
  logic         i_PixReady;
  logic [W-1:0] o_PixX, o_PixY;

  logic         o_Busy;
  logic         o_Done;

  modport slave (
    input  i_CfgWe, i_CfgAddr, i_CfgData, i_Start, i_VtxCount,
           i_VtxValid, i_VertexX, i_VertexY, i_VertexZ,
           i_GpPixX, i_GpPixY, i_PixReady,
    output o_CfgErr, o_VtxReady,
           o_CamVerX, o_CamVerY, o_CamVerZ, o_CamDc,
           o_CosRoll, o_CosPitch, o_CosYaw,
           o_SenRoll, o_SenPitch, o_SenYaw,
           o_ScaleX, o_ScaleY, o_ScaleZ,
           o_TranslX, o_TranslY, o_TranslZ,
           o_VertexX, o_VertexY, o_VertexZ,
           o_PixValid, o_PixX, o_PixY, o_Busy, o_Done
  );

  modport master (
    output i_CfgWe, i_CfgAddr, i_CfgData, i_Start, i_VtxCount,
           i_VtxValid, i_VertexX, i_VertexY, i_VertexZ,
           i_GpPixX, i_GpPixY, i_PixReady,
    input  o_CfgErr, o_VtxReady,
           o_CamVerX, o_CamVerY, o_CamVerZ, o_CamDc,
           o_CosRoll, o_CosPitch, o_CosYaw,
           o_SenRoll, o_SenPitch, o_SenYaw,
           o_ScaleX, o_ScaleY, o_ScaleZ,
           o_TranslX, o_TranslY, o_TranslZ,
           o_VertexX, o_VertexY, o_VertexZ,
           o_PixValid, o_PixX, o_PixY, o_Busy, o_Done
  );

endinterface

`default_nettype wire

// File: rtl/gp_param_regs.sv
//============================================================================
// Module : gp_param_regs
// Brief  : 16-entry parameter register file with write decode and a
//          one-cycle error pulse for rejected writes.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module gp_param_regs import gp_pkg::*; #(
  parameter int W = c_w
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic [4:0]   i_addr,
  input  logic [W-1:0] i_data,
  input  logic         i_busy,
  output logic         o_err,
  output logic [W-1:0] o_regs [c_num_regs]
);

  logic [W-1:0] r_regs [c_num_regs];
  logic         r_err;
  logic         w_reject;
  logic         w_accept;

  // Parameters are frozen while an object is in flight.
  assign w_reject = i_we && (i_busy || (i_addr > 5'(c_addr_transl_z)));
  assign w_accept = i_we && !w_reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_num_regs; i++) begin
        r_regs[i] <= '0;
      end
      r_err <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_regs[i_addr[3:0]] <= i_data;
      end
    end
  end

  assign o_regs = r_regs;
  assign o_err  = r_err;

endmodule

`default_nettype wire

// File: rtl/gp_sequencer.sv
//============================================================================
// Module : gp_sequencer
// Brief  : Feeds vertices one at a time to an external graphics pipeline,
//          waits its fixed latency and streams back the resulting pixels.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module gp_sequencer import gp_pkg::*; #(
  parameter int PIPE_LAT = 4,
  parameter int W        = c_w
) (
  input logic           i_Clk,
  input logic           i_Reset,
  gp_sequencer_if.slave bus
);

  localparam logic [3:0] c_lat_load = 4'(PIPE_LAT);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [15:0]  r_remaining;
  logic [3:0]   r_lat;
  logic [W-1:0] r_vtx_x, r_vtx_y, r_vtx_z;
  logic [W-1:0] r_pix_x, r_pix_y;
  logic [W-1:0] w_regs [c_num_regs];
  logic         w_busy;
  logic         w_vtx_hs;
  logic         w_lat_last;
  logic         w_pix_xfer;

  assign w_busy     = (r_state != ST_IDLE);
  assign w_vtx_hs   = (r_state == ST_FETCH) && bus.i_VtxValid;
  assign w_lat_last = (r_state == ST_WAIT) && (r_lat <= 4'd1);
  assign w_pix_xfer = (r_state == ST_OUTPUT) && bus.i_PixReady;

  gp_param_regs #(.W(W)) u_param_regs (
    .clk    (i_Clk),
    .rst    (i_Reset),
    .i_we   (bus.i_CfgWe),
    .i_addr (bus.i_CfgAddr),
    .i_data (bus.i_CfgData),
    .i_busy (w_busy),
    .o_err  (bus.o_CfgErr),
    .o_regs (w_regs)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_Start) begin
          w_state_nxt = (bus.i_VtxCount == 16'd0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.i_VtxValid) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_lat_last) begin
          w_state_nxt = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (bus.i_PixReady) begin
          w_state_nxt = (r_remaining == 16'd1) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_remaining <= '0;
      r_lat       <= '0;
      r_vtx_x     <= '0;
      r_vtx_y     <= '0;
      r_vtx_z     <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
    end else begin
      if ((r_state == ST_IDLE) && bus.i_Start) begin
        r_remaining <= bus.i_VtxCount;
      end
      if (w_vtx_hs) begin
        r_vtx_x <= bus.i_VertexX;
        r_vtx_y <= bus.i_VertexY;
        r_vtx_z <= bus.i_VertexZ;
        r_lat   <= c_lat_load;
      end
      if (r_state == ST_WAIT) begin
        r_lat <= r_lat - 4'd1;
      end
      // Last WAIT cycle lands exactly PIPE_LAT edges after the handshake.
      if (w_lat_last) begin
        r_pix_x <= bus.i_GpPixX;
        r_pix_y <= bus.i_GpPixY;
      end
      if (w_pix_xfer) begin
        r_remaining <= r_remaining - 16'd1;
      end
    end
  end

  assign bus.o_Busy     = w_busy;
  assign bus.o_VtxReady = (r_state == ST_FETCH);
  assign bus.o_PixValid = (r_state == ST_OUTPUT);
  assign bus.o_Done     = (r_state == ST_DONE);
  assign bus.o_PixX     = r_pix_x;
  assign bus.o_PixY     = r_pix_y;
  assign bus.o_VertexX  = r_vtx_x;
  assign bus.o_VertexY  = r_vtx_y;
  assign bus.o_VertexZ  = r_vtx_z;

  assign bus.o_CamVerX  = w_regs[c_addr_cam_ver_x];
  assign bus.o_CamVerY  = w_regs[c_addr_cam_ver_y];
  assign bus.o_CamVerZ  = w_regs[c_addr_cam_ver_z];
  assign bus.o_CamDc    = w_regs[c_addr_cam_dc];
  assign bus.o_CosRoll  = w_regs[c_addr_cos_roll];
  assign bus.o_CosPitch = w_regs[c_addr_cos_pitch];
  assign bus.o_CosYaw   = w_regs[c_addr_cos_yaw];
  assign bus.o_SenRoll  = w_regs[c_addr_sen_roll];
  assign bus.o_SenPitch = w_regs[c_addr_sen_pitch];
  assign bus.o_SenYaw   = w_regs[c_addr_sen_yaw];
  assign bus.o_ScaleX   = w_regs[c_addr_scale_x];
  assign bus.o_ScaleY   = w_regs[c_addr_scale_y];
  assign bus.o_ScaleZ   = w_regs[c_addr_scale_z];
  assign bus.o_TranslX  = w_regs[c_addr_transl_x];
  assign bus.o_TranslY  = w_regs[c_addr_transl_y];
  assign bus.o_TranslZ  = w_regs[c_addr_transl_z];

endmodule

`default_nettype wire

// File: tb/tb_gp_sequencer.sv
//============================================================================
// Module : tb_gp_sequencer
// Brief  : Directed bench for gp_sequencer with a latency-exact pipeline model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_gp_sequencer;

  localparam int PL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   done_cnt = 0;
  logic [7:0]  hs_cnt = 8'hFF;
  logic [15:0] cur_px = 16'h0;
  logic [15:0] cur_py = 16'h0;

  gp_sequencer_if #(.W(16)) bus ();

  gp_sequencer #(.PIPE_LAT(PL), .W(16)) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Pipeline model: result is only valid in the cycle the sequencer must sample it.
  always @(posedge clk) begin
    if (bus.i_VtxValid && bus.o_VtxReady) hs_cnt <= 8'd0;
    else if (hs_cnt != 8'hFF)             hs_cnt <= hs_cnt + 8'd1;
    if (bus.o_Done) done_cnt <= done_cnt + 1;
  end
  assign bus.i_GpPixX = (hs_cnt == 8'(PL - 1)) ? cur_px : 16'hBAD0;
  assign bus.i_GpPixY = (hs_cnt == 8'(PL - 1)) ? cur_py : 16'hBAD1;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
    logic        err;
    int          idx;
    logic [15:0] val;
  } cfg_vec_t;

  cfg_vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] get_reg(input int idx);
    case (idx)
      0:  return bus.o_CamVerX;
      1:  return bus.o_CamVerY;
      2:  return bus.o_CamVerZ;
      3:  return bus.o_CamDc;
      4:  return bus.o_CosRoll;
      5:  return bus.o_CosPitch;
      6:  return bus.o_CosYaw;
      7:  return bus.o_SenRoll;
      8:  return bus.o_SenPitch;
      9:  return bus.o_SenYaw;
      10: return bus.o_ScaleX;
      11: return bus.o_ScaleY;
      12: return bus.o_ScaleZ;
      13: return bus.o_TranslX;
      14: return bus.o_TranslY;
      default: return bus.o_TranslZ;
    endcase
  endfunction

  task automatic outputs_zero(input string tag);
    chk({tag, "_flags"}, {bus.o_Busy, bus.o_VtxReady, bus.o_PixValid, bus.o_Done, bus.o_CfgErr}, 64'd0);
    chk({tag, "_params"}, {bus.o_CamVerX, bus.o_CosRoll, bus.o_TranslX, bus.o_TranslZ}, 64'd0);
    chk({tag, "_data"}, {bus.o_VertexX, bus.o_VertexZ, bus.o_PixX, bus.o_PixY}, 64'd0);
  endtask

  task automatic start_obj(input logic [15:0] cnt);
    bus.i_Start    = 1'b1;
    bus.i_VtxCount = cnt;
    tick();
    bus.i_Start    = 1'b0;
    bus.i_VtxCount = 16'hFFFF;
  endtask

  task automatic run_vertex(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input logic [15:0] px, input logic [15:0] py,
                            input int stall, input bit last);
    int n;
    bit ok;
    n = 0;
    while (!bus.o_VtxReady && n < 10) begin
      tick();
      n++;
    end
    chk("vtx_ready", bus.o_VtxReady, 64'd1);
    cur_px = px;
    cur_py = py;
    bus.i_VertexX  = x;
    bus.i_VertexY  = y;
    bus.i_VertexZ  = z;
    bus.i_VtxValid = 1'b1;
    bus.i_PixReady = (stall == 0);
    tick();
    bus.i_VtxValid = 1'b0;
    bus.i_VertexX  = 16'hFFFF;
    bus.i_VertexY  = 16'hFFFF;
    bus.i_VertexZ  = 16'hFFFF;
    chk("vertex_drive", {bus.o_VertexX, bus.o_VertexY, bus.o_VertexZ}, {16'h0, x, y, z});
    n = 0;
    while (!bus.o_PixValid && n < 20) begin
      tick();
      n++;
    end
    chk("pix_latency", 64'(n), 64'(PL));
    chk("pix_value", {bus.o_PixX, bus.o_PixY}, {32'h0, px, py});
    chk("vertex_hold", {bus.o_VertexX, bus.o_VertexY, bus.o_VertexZ, bus.o_VtxReady},
        {15'h0, x, y, z, 1'b0});
    if (stall > 0) begin
      ok = 1'b1;
      repeat (stall) begin
        tick();
        if (!bus.o_PixValid || bus.o_PixX !== px || bus.o_PixY !== py || bus.o_VtxReady) ok = 1'b0;
      end
      chk("stall_hold", 64'(ok), 64'd1);
      bus.i_PixReady = 1'b1;
    end
    tick();
    bus.i_PixReady = 1'b0;
    chk("pix_drop", bus.o_PixValid, 64'd0);
    if (last) begin
      chk("done_pulse", {bus.o_Done, bus.o_VtxReady}, 64'b10);
      tick();
      chk("done_clear", {bus.o_Done, bus.o_Busy}, 64'd0);
    end else begin
      chk("next_ready", {bus.o_VtxReady, bus.o_Done}, 64'b10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bus.i_CfgWe = 1'b0;   bus.i_CfgAddr = '0;  bus.i_CfgData = '0;
    bus.i_Start = 1'b0;   bus.i_VtxCount = '0;
    bus.i_VtxValid = 1'b0;
    bus.i_VertexX = '0;   bus.i_VertexY = '0;  bus.i_VertexZ = '0;
    bus.i_PixReady = 1'b0;

    tbl[0] = '{5'd13, 16'hC799, 1'b0, 13, 16'hC799};
    tbl[1] = '{5'd14, 16'hC300, 1'b0, 14, 16'hC300};
    tbl[2] = '{5'd15, 16'h4E40, 1'b0, 15, 16'h4E40};
    tbl[3] = '{5'd20, 16'hFFFF, 1'b1, 4,  16'h0000};
    tbl[4] = '{5'd0,  16'h3C00, 1'b0, 0,  16'h3C00};
    tbl[5] = '{5'd4,  16'h1111, 1'b0, 4,  16'h1111};
    tbl[6] = '{5'd31, 16'h2222, 1'b1, 15, 16'h4E40};
    tbl[7] = '{5'd9,  16'hABCD, 1'b0, 9,  16'hABCD};

    tick();
    tick();
    outputs_zero("reset");
    rst = 1'b0;
    tick();

    // Config writes in IDLE
    for (int i = 0; i < 8; i++) begin
      bus.i_CfgWe   = 1'b1;
      bus.i_CfgAddr = tbl[i].addr;
      bus.i_CfgData = tbl[i].data;
      tick();
      bus.i_CfgWe   = 1'b0;
      chk($sformatf("cfg_err[%0d]", i), bus.o_CfgErr, 64'(tbl[i].err));
      chk($sformatf("cfg_reg[%0d]", i), get_reg(tbl[i].idx), 64'(tbl[i].val));
    end
    tick();
    chk("cfg_err_clear", bus.o_CfgErr, 64'd0);

    // Single vertex object
    start_obj(16'd1);
    run_vertex(16'h4780, 16'h4780, 16'hC500, 16'h1234, 16'h5678, 0, 1'b1);

    // Three-vertex object with busy write, ignored start and a stalled output
    d0 = done_cnt;
    start_obj(16'd3);
    bus.i_CfgWe    = 1'b1;
    bus.i_CfgAddr  = 5'd4;
    bus.i_CfgData  = 16'h9999;
    bus.i_Start    = 1'b1;
    bus.i_VtxCount = 16'd0;
    tick();
    bus.i_CfgWe = 1'b0;
    bus.i_Start = 1'b0;
    chk("busy_cfg_err", bus.o_CfgErr, 64'd1);
    chk("busy_cfg_reg", bus.o_CosRoll, 64'h1111);
    chk("start_ignored", {bus.o_Busy, bus.o_VtxReady, bus.o_Done}, 64'b110);
    run_vertex(16'h0001, 16'h0002, 16'h0003, 16'hA001, 16'hB001, 0, 1'b0);
    run_vertex(16'h0011, 16'h0012, 16'h0013, 16'hA002, 16'hB002, 5, 1'b0);
    run_vertex(16'h0021, 16'h0022, 16'h0023, 16'hA003, 16'hB003, 0, 1'b1);
    chk("obj3_done_count", 64'(done_cnt - d0), 64'd1);
    chk("params_retained", {bus.o_TranslX, bus.o_TranslY, bus.o_TranslZ}, {16'h0, 48'hC799_C300_4E40});

    // Zero-length object
    start_obj(16'd0);
    chk("zero_done", {bus.o_Done, bus.o_VtxReady, bus.o_PixValid}, 64'b100);
    tick();
    chk("zero_idle", {bus.o_Done, bus.o_Busy, bus.o_VtxReady, bus.o_PixValid}, 64'd0);

    // Reset during WAIT, with start and config write competing
    d0 = done_cnt;
    start_obj(16'd2);
    bus.i_VertexX  = 16'h0101;
    bus.i_VtxValid = 1'b1;
    cur_px = 16'h7777;
    cur_py = 16'h8888;
    tick();
    bus.i_VtxValid = 1'b0;
    tick();
    tick();
    chk("pre_reset_wait", {bus.o_Busy, bus.o_VtxReady, bus.o_PixValid}, 64'b100);
    rst = 1'b1;
    bus.i_Start    = 1'b1;
    bus.i_VtxCount = 16'd1;
    bus.i_CfgWe    = 1'b1;
    bus.i_CfgAddr  = 5'd0;
    bus.i_CfgData  = 16'h7777;
    tick();
    rst = 1'b0;
    bus.i_Start = 1'b0;
    bus.i_CfgWe = 1'b0;
    outputs_zero("abort");
    repeat (6) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_idle", {bus.o_Busy, bus.o_PixValid}, 64'd0);
    start_obj(16'd1);
    run_vertex(16'h4000, 16'h4100, 16'h4200, 16'h0F0F, 16'hF0F0, 0, 1'b1);
    chk("restart_done_count", 64'(done_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gp_sequencer.md
GP_SEQUENCER -- requirements
Module: gp_sequencer

Interface
REQ-001 Parameter PIPE_LAT, default 4, graphics pipeline result latency in clocks (1..15).
REQ-002 Parameter W, default 16, half-float word width.
REQ-003 i_Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 i_CfgWe  in  1  config write strobe.
REQ-006 i_CfgAddr  in  5  register index: 0-2 CamVerX/Y/Z, 3 CamDc, 4-6 CosRoll/Pitch/Yaw, 7-9 SenRoll/Pitch/Yaw, 10-12 ScaleX/Y/Z, 13-15 TranslX/Y/Z.
REQ-007 i_CfgData  in  W  config write data.
REQ-008 o_CfgErr  out  1  one-cycle pulse on a rejected write.
REQ-009 i_Start  in  1  start-object strobe; i_VtxCount  in  16  vertices in object.
REQ-010 i_VtxValid  in  1, o_VtxReady  out  1, i_VertexX/Y/Z  in  W each  vertex stream.
REQ-011 o_CamVerX..o_TranslZ  out  W each  16 registered parameter drives to graphicspipeline, same names as its i_ ports.
REQ-012 o_VertexX/Y/Z  out  W each  registered vertex drive to graphicspipeline.
REQ-013 i_GpPixX, i_GpPixY  in  W each  pipeline result.
REQ-014 o_PixValid  out  1, i_PixReady  in  1, o_PixX/o_PixY  out  W each  result stream.
REQ-015 o_Busy  out  1  high in any state but IDLE; o_Done  out  1  one-cycle end-of-object pulse.

Function
REQ-016 FSM states IDLE, FETCH, WAIT, OUTPUT, DONE; IDLE is the reset state.
REQ-017 IDLE: i_CfgWe with i_CfgAddr<=15 writes register next cycle; address 16-31 rejected, o_CfgErr pulses.
REQ-018 i_CfgWe while o_Busy=1 rejected, register unchanged, o_CfgErr pulses.
REQ-019 IDLE + i_Start: i_VtxCount latched into remaining counter; count 0 -> DONE, else -> FETCH.
REQ-020 i_Start outside IDLE ignored, no side effects.
REQ-021 FETCH: o_VtxReady=1; on i_VtxValid&&o_VtxReady vertex registered onto o_VertexX/Y/Z, latency counter loaded with PIPE_LAT, -> WAIT; o_VtxReady=0 in all other states.
REQ-022 WAIT: counter decrements each cycle; at 1, i_GpPixX/Y captured into o_PixX/Y, o_PixValid set, -> OUTPUT; capture exactly PIPE_LAT cycles after the handshake edge.
REQ-023 Parameter and vertex drives stay stable from handshake until capture.
REQ-024 OUTPUT: o_PixValid, o_PixX/Y held until i_PixReady; on transfer remaining decrements; 0 -> DONE, else -> FETCH.
REQ-025 i_PixReady high on arrival in OUTPUT: transfer in that same cycle.
REQ-026 DONE: o_Done=1 one cycle, -> IDLE; parameter registers retained across objects.
REQ-027 One vertex in flight; next o_VtxReady at earliest the cycle after the output transfer.
REQ-028 Remaining counter 16-bit unsigned; 65535 vertices legal, no wrap.

Reset
REQ-029 i_Reset high: state IDLE, all parameter/vertex/pixel registers 0, o_PixValid, o_VtxReady, o_Done, o_CfgErr, o_Busy 0, counters 0.
REQ-030 Reset mid-object aborts immediately; no o_Done, pending pixel discarded.
REQ-031 Reset dominates i_Start and i_CfgWe in the same cycle.

Structure
REQ-032 Shared package gp_pkg: W, config address constants 0-15, FSM state encoding.
REQ-033 One sub-module gp_param_regs (16xW register file, write decode, error flag); FSM, counters, vertex/pixel registers in gp_sequencer.
REQ-034 graphicspipeline instantiated by the parent, not inside gp_sequencer.

Verification
REQ-035 Write addr 13-15 = 0xC799, 0xC300, 0x4E40 in IDLE -> o_TranslX/Y/Z equal those values next cycle, o_CfgErr 0.
REQ-036 Write addr 20 in IDLE, and addr 4 while busy -> o_CfgErr pulses each time, registers unchanged.
REQ-037 Start count 1, vertex (0x4780,0x4780,0xC500), model returns 0x1234/0x5678 -> o_PixValid exactly PIPE_LAT cycles after handshake, o_PixX=0x1234, o_PixY=0x5678, o_Done one cycle after transfer.
REQ-038 Start count 3, i_PixReady low 5 cycles on vertex 2 -> pixel held stable, no o_VtxReady until transfer, three pixels in order, one o_Done.
REQ-039 Start count 0 -> o_Done next cycle, no o_VtxReady, no o_PixValid.
REQ-040 Reset during WAIT of count-2 object -> all outputs 0 next cycle, no o_Done, new start then runs normally.
